// File: rtl/machine_timer.sv
// Memory-mapped RISC-V machine timer (mtime/mtimecmp) and software-interrupt register
// on the CPU data-memory port, with one-cycle registered read data.
module machine_timer #(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
    parameter int unsigned PRESCALE  = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_data_mem_addr,
    input  logic [31:0] i_data_mem_wr_data,
    input  logic [3:0]  i_data_mem_per_byte_wr_en,
    output logic [31:0] o_rd_data,
    output logic        o_rd_hit,
    output logic [63:0] o_mtime,
    output logic        o_mtip,
    output logic        o_msip
);

    localparam int unsigned PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    localparam logic [2:0] OFF_MTIME_LO = 3'd0;
    localparam logic [2:0] OFF_MTIME_HI = 3'd1;
    localparam logic [2:0] OFF_CMP_LO   = 3'd2;
    localparam logic [2:0] OFF_CMP_HI   = 3'd3;
    localparam logic [2:0] OFF_MSIP     = 3'd4;

    logic [PS_W-1:0] ps_q, ps_d;
    logic [63:0]     mtime_q, mtime_d;
    logic [63:0]     mtimecmp_q, mtimecmp_d;
    logic            msip_q, msip_d;
    logic [31:0]     rd_data_q, rd_data_d;
    logic            rd_hit_q, rd_hit_d;
    logic            mtip_q, mtip_d;

    logic            hit_c;
    logic [2:0]      off_c;
    logic            wr_c;
    logic            tick_c;
    logic            unused_c;

    assign unused_c = ^i_data_mem_addr[1:0];

    // Byte-enable merge of a 32-bit write into an existing register half.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  be);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = new_v[8*b +: 8];
        end
        return r;
    endfunction

    always_comb begin
        hit_c      = (i_data_mem_addr[31:5] == BASE_ADDR[31:5]);
        off_c      = i_data_mem_addr[4:2];
        wr_c       = hit_c && (|i_data_mem_per_byte_wr_en);
        tick_c     = (ps_q == PS_LAST);

        ps_d       = tick_c ? '0 : ps_q + PS_W'(1);
        mtime_d    = mtime_q;
        mtimecmp_d = mtimecmp_q;
        msip_d     = msip_q;
        rd_data_d  = '0;
        rd_hit_d   = hit_c;
        mtip_d     = (mtime_q >= mtimecmp_q);

        // A CPU write to mtime replaces that cycle's increment; the tick is dropped.
        if (wr_c && off_c == OFF_MTIME_LO) begin
            mtime_d[31:0] = merge_bytes(mtime_q[31:0], i_data_mem_wr_data,
                                        i_data_mem_per_byte_wr_en);
        end else if (wr_c && off_c == OFF_MTIME_HI) begin
            mtime_d[63:32] = merge_bytes(mtime_q[63:32], i_data_mem_wr_data,
                                         i_data_mem_per_byte_wr_en);
        end else if (tick_c) begin
            mtime_d = mtime_q + 64'd1;
        end

        if (wr_c && off_c == OFF_CMP_LO) begin
            mtimecmp_d[31:0] = merge_bytes(mtimecmp_q[31:0], i_data_mem_wr_data,
                                           i_data_mem_per_byte_wr_en);
        end
        if (wr_c && off_c == OFF_CMP_HI) begin
            mtimecmp_d[63:32] = merge_bytes(mtimecmp_q[63:32], i_data_mem_wr_data,
                                            i_data_mem_per_byte_wr_en);
        end
        if (wr_c && off_c == OFF_MSIP && i_data_mem_per_byte_wr_en[0]) begin
            msip_d = i_data_mem_wr_data[0];
        end

        // Read-first: captures pre-edge register contents.
        if (hit_c) begin
            case (off_c)
                OFF_MTIME_LO: rd_data_d = mtime_q[31:0];
                OFF_MTIME_HI: rd_data_d = mtime_q[63:32];
                OFF_CMP_LO:   rd_data_d = mtimecmp_q[31:0];
                OFF_CMP_HI:   rd_data_d = mtimecmp_q[63:32];
                OFF_MSIP:     rd_data_d = {31'd0, msip_q};
                default:      rd_data_d = '0;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ps_q       <= '0;
            mtime_q    <= '0;
            mtimecmp_q <= '1;
            msip_q     <= 1'b0;
            rd_data_q  <= '0;
            rd_hit_q   <= 1'b0;
            mtip_q     <= 1'b0;
        end else begin
            ps_q       <= ps_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            msip_q     <= msip_d;
            rd_data_q  <= rd_data_d;
            rd_hit_q   <= rd_hit_d;
            mtip_q     <= mtip_d;
        end
    end

    assign o_rd_data = rd_data_q;
    assign o_rd_hit  = rd_hit_q;
    assign o_mtime   = mtime_q;
    assign o_mtip    = mtip_q;
    assign o_msip    = msip_q;

endmodule

// File: tb/tb_machine_timer.sv
// Self-checking bench for machine_timer: directed scenarios plus random bus traffic
// against a behavioural register-map model; a PRESCALE=4 instance checks tick spacing.
module tb_machine_timer;

    localparam logic [31:0] BASE = 32'h4000_0000;
    localparam int P1 = 1;
    localparam int P4 = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr = 32'd0;
    logic [31:0] wd = 32'd0;
    logic [3:0]  be = 4'd0;

    logic [31:0] o_rd_data;
    logic        o_rd_hit;
    logic [63:0] o_mtime;
    logic        o_mtip;
    logic        o_msip;

    logic [31:0] idle_addr = 32'd0;
    logic [31:0] idle_wd = 32'd0;
    logic [3:0]  idle_be = 4'd0;
    logic [31:0] rd_data4;
    logic        rd_hit4;
    logic [63:0] mtime4;
    logic        mtip4;
    logic        msip4;

    machine_timer #(.BASE_ADDR(BASE), .PRESCALE(P1)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_data_mem_addr(addr), .i_data_mem_wr_data(wd), .i_data_mem_per_byte_wr_en(be),
        .o_rd_data(o_rd_data), .o_rd_hit(o_rd_hit), .o_mtime(o_mtime),
        .o_mtip(o_mtip), .o_msip(o_msip)
    );

    machine_timer #(.BASE_ADDR(BASE), .PRESCALE(P4)) dut4 (
        .i_clk(clk), .i_rst(rst),
        .i_data_mem_addr(idle_addr), .i_data_mem_wr_data(idle_wd),
        .i_data_mem_per_byte_wr_en(idle_be),
        .o_rd_data(rd_data4), .o_rd_hit(rd_hit4), .o_mtime(mtime4),
        .o_mtip(mtip4), .o_msip(msip4)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: register map as plain 64-bit values, ticks from an edge count.
    logic [63:0] m_mtime = 64'd0;
    logic [63:0] m_cmp = '1;
    logic        m_msip = 1'b0;
    logic [31:0] e_rd = 32'd0;
    logic        e_hit = 1'b0;
    logic        e_mtip = 1'b0;
    int          m_cnt = 0;
    logic        m_win;
    logic [2:0]  m_off;
    logic        m_tick;

    function automatic logic [31:0] m_read(input logic [2:0] off);
        case (off)
            3'd0: return m_mtime[31:0];
            3'd1: return m_mtime[63:32];
            3'd2: return m_cmp[31:0];
            3'd3: return m_cmp[63:32];
            3'd4: return {31'd0, m_msip};
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mtime = 64'd0; m_cmp = '1; m_msip = 1'b0;
            e_rd = 32'd0; e_hit = 1'b0; e_mtip = 1'b0; m_cnt = 0;
        end else begin
            m_win  = (addr[31:5] == BASE[31:5]);
            m_off  = addr[4:2];
            e_hit  = m_win;
            e_rd   = m_win ? m_read(m_off) : 32'd0;
            e_mtip = (m_mtime >= m_cmp);
            m_tick = ((m_cnt % P1) == P1 - 1);
            m_cnt++;
            if (m_win && be != 4'd0 && m_off <= 3'd1) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) m_mtime[int'(m_off)*32 + 8*b +: 8] = wd[8*b +: 8];
            end else if (m_tick) begin
                m_mtime = m_mtime + 64'd1;
            end
            if (m_win && (m_off == 3'd2 || m_off == 3'd3)) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) m_cmp[(int'(m_off)-2)*32 + 8*b +: 8] = wd[8*b +: 8];
            end
            if (m_win && m_off == 3'd4 && be[0]) m_msip = wd[0];
        end
    end

    always @(negedge clk) begin
        chk("mtime", o_mtime, m_mtime);
        chk("mtip", 64'(o_mtip), 64'(e_mtip));
        chk("msip", 64'(o_msip), 64'(m_msip));
        chk("rd_data", 64'(o_rd_data), 64'(e_rd));
        chk("rd_hit", 64'(o_rd_hit), 64'(e_hit));
        chk("mtime_ps4", mtime4, 64'(m_cnt / P4));
        chk("idle_ps4", {rd_data4, 29'd0, rd_hit4, mtip4, msip4}, 64'd0);
    end

    task automatic cyc(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        @(negedge clk);
        addr = a; wd = d; be = b;
    endtask

    task automatic idle();
        cyc(32'd0, 32'd0, 4'd0);
    endtask

    logic [31:0] lo_before, hi_before;
    logic        seen;
    int          r;
    logic [2:0]  roff;

    initial begin
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) idle();
        chk("idle10_mtime", o_mtime, 64'd10);
        chk("idle10_mtip", 64'(o_mtip), 64'd0);
        chk("idle10_hit", 64'(o_rd_hit), 64'd0);
        for (int i = 0; i < 6; i++) idle();
        chk("ps4_16_edges", mtime4, 64'd4);
        chk("ps1_16_edges", o_mtime, 64'd16);

        // Timer interrupt
        cyc(BASE + 32'h08, 32'h20, 4'hF);
        cyc(BASE + 32'h0C, 32'h0, 4'hF);
        seen = 1'b0;
        for (int k = 0; k < 64 && !seen; k++) begin
            idle();
            if (o_mtime == 64'h20) seen = 1'b1;
        end
        chk("reach_mtime_20", 64'(seen), 64'd1);
        chk("mtip_at_eq", 64'(o_mtip), 64'd0);
        idle();
        chk("mtip_rise", 64'(o_mtip), 64'd1);
        cyc(BASE + 32'h0C, 32'h1, 4'hF);
        idle();
        chk("mtip_hold", 64'(o_mtip), 64'd1);
        idle();
        chk("mtip_clear", 64'(o_mtip), 64'd0);

        // Partial mtime write with same-cycle read
        cyc(BASE + 32'h04, 32'hAABB_CCDD, 4'b0101);
        lo_before = o_mtime[31:0];
        hi_before = o_mtime[63:32];
        cyc(BASE + 32'h04, 32'd0, 4'd0);
        chk("rd_first_old", 64'(o_rd_data), 64'(hi_before));
        chk("mtime_hi_written", 64'(o_mtime[63:32]), 64'h00BB_00DD);
        chk("mtime_lo_no_inc", 64'(o_mtime[31:0]), 64'(lo_before));
        idle();
        chk("rd_new_hi", 64'(o_rd_data), 64'h00BB_00DD);

        // Wrap
        cyc(BASE + 32'h00, 32'hFFFF_FFFF, 4'hF);
        cyc(BASE + 32'h04, 32'hFFFF_FFFF, 4'hF);
        idle();
        chk("mtime_all_ones", o_mtime, 64'hFFFF_FFFF_FFFF_FFFF);
        idle();
        chk("mtime_wrap", o_mtime, 64'd0);

        // Unmapped offset and out-of-window
        cyc(BASE + 32'h18, 32'd0, 4'd0);
        idle();
        chk("rd_0x18_data", 64'(o_rd_data), 64'd0);
        chk("rd_0x18_hit", 64'(o_rd_hit), 64'd1);
        cyc(BASE + 32'h20, 32'd0, 4'd0);
        idle();
        chk("rd_out_hit", 64'(o_rd_hit), 64'd0);
        chk("rd_out_data", 64'(o_rd_data), 64'd0);

        // msip
        cyc(BASE + 32'h10, 32'hFFFF_FFFF, 4'hF);
        cyc(BASE + 32'h10, 32'd0, 4'd0);
        chk("msip_set", 64'(o_msip), 64'd1);
        idle();
        chk("msip_read", 64'(o_rd_data), 64'd1);

        // Mid-count asynchronous reset
        cyc(BASE + 32'h10, 32'd0, 4'd0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mtime", o_mtime, 64'd0);
        chk("rst_rd", {o_rd_data, 29'd0, o_rd_hit, o_mtip, o_msip}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        addr = 32'd0; wd = 32'd0; be = 4'd0;
        cyc(BASE + 32'h08, 32'd0, 4'd0);
        cyc(BASE + 32'h0C, 32'd0, 4'd0);
        chk("cmp_lo_reset", 64'(o_rd_data), 64'hFFFF_FFFF);
        idle();
        chk("cmp_hi_reset", 64'(o_rd_data), 64'hFFFF_FFFF);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 9);
            roff = 3'($urandom_range(0, 7));
            if (r == 0) begin
                addr = BASE ^ (32'd1 << $urandom_range(5, 31));
            end else begin
                addr = BASE | {27'd0, roff, 2'($urandom_range(0, 3))};
            end
            cyc(addr,
                ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 64)) : $urandom,
                ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15)));
        end
        idle();
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/machine_timer.md
# machine_timer

Memory-mapped RISC-V machine timer and software-interrupt responder on the CPU data-memory port. It decodes the CPU's address, write-data and byte-enable outputs and returns read data with the same one-cycle latency as the data block RAM. It sources the 64-bit `mtime` value and the MTIP/MSIP bits of the CPU's `interrupt_t` input. It sits beside the data RAM; the top level muxes `o_rd_data` into the CPU read path using `o_rd_hit`.

## Interface
- `BASE_ADDR`, default 32'h4000_0000: byte base of the register window. Must be 32-byte aligned.
- `PRESCALE`, default 1: `i_clk` cycles per `mtime` increment. Must be ≥1.
- `i_clk` input 1: the single clock; all state on its rising edge.
- `i_rst` input 1: reset, asynchronous and active-high.
- `i_data_mem_addr` input 32: CPU data byte address.
- `i_data_mem_wr_data` input 32: CPU write data.
- `i_data_mem_per_byte_wr_en` input 4: per-byte write enables; bit n covers bits [8n+7:8n].
- `o_rd_data` output 32: registered read data, valid the cycle after the address.
- `o_rd_hit` output 1: registered flag; the previous-cycle address fell in the window.
- `o_mtime` output 64: current `mtime` register.
- `o_mtip` output 1: machine timer interrupt pending.
- `o_msip` output 1: machine software interrupt pending.

## Operation
- **Window hit:** `i_data_mem_addr[31:5] == BASE_ADDR[31:5]`. The word offset is `addr[4:2]`; `addr[1:0]` is ignored.
- **Register map:**
  - 0x00: `mtime[31:0]`
  - 0x04: `mtime[63:32]`
  - 0x08: `mtimecmp[31:0]`
  - 0x0C: `mtimecmp[63:32]`
  - 0x10: `msip` (bit 0 only; bits 31:1 read 0, ignored on write)
  - 0x14–0x1C: read 0, writes ignored.
- **Writes:** on a hit, each enabled byte updates the corresponding byte of the addressed register at the clock edge. Non-hits are ignored entirely.
- **Prescaler:** counter `ps` runs 0..PRESCALE-1 and wraps.
  - A tick occurs in a cycle where `ps == PRESCALE-1`.
  - With PRESCALE=1, every cycle is a tick.
- **mtime increment:** on a tick, `mtime <= mtime + 1`, 64-bit, wrapping 2^64-1 → 0.
- **mtime write priority:** in any cycle with a byte enable set on offset 0x00 or 0x04, the write wins.
  - The unwritten bytes and the other half hold their value; no increment occurs that cycle.
  - `ps` keeps running; the tick is lost, not deferred.
- **Timer interrupt:** `o_mtip <= (mtime >= mtimecmp)`, unsigned 64-bit, evaluated on the current register values each cycle.
- **Software interrupt:** `o_msip` is the `msip` register directly.
- **Reads:** read-first. `o_rd_data` captures the pre-edge value of the addressed register, so a same-cycle write does not show until the next access.
  - On a non-hit, `o_rd_data <= 0` and `o_rd_hit <= 0`.
- **No read-enable:** every hit cycle updates `o_rd_data`, and reads have no side effects.

## Timing
- **Reset values** (asynchronous, immediate on `i_rst` rise):
  - `mtime` = 0, `ps` = 0, `msip` = 0
  - `mtimecmp` = 64'hFFFF_FFFF_FFFF_FFFF
  - `o_rd_data` = 0, `o_rd_hit` = 0, `o_mtip` = 0, `o_msip` = 0
- **Reset release:** the first tick occurs PRESCALE edges after release.
- **Read latency:** exactly 1 cycle from the address to `o_rd_data`/`o_rd_hit`. Back-to-back reads are allowed every cycle.
- **Write latency:** the register value is visible on `o_mtime`/`o_msip` the cycle after the write edge. `o_mtip` reflects it one further cycle later.
- **Compare latency:** `o_mtip` rises 1 cycle after `mtime` first equals `mtimecmp`. It falls 1 cycle after a write makes `mtimecmp > mtime`.
- **Mid-operation reset:** any in-flight read result is discarded and all outputs return to their reset values in the same cycle.

## Test plan
- **Reset, then idle 10 cycles (PRESCALE=1):**
  - `o_mtime` = 9 or 10 per edge count.
  - `o_mtip` = 0 throughout, `o_rd_hit` = 0.
- **PRESCALE=4, count 16 cycles after reset:** `o_mtime` = 4, incrementing on every 4th edge only.
- **Timer interrupt:**
  - Stimulus: write 0x08 = 0x20, byte-enable 4'hF; write 0x0C = 0; then run until `mtime` = 0x20.
  - Response: `o_mtip` = 1 one cycle later. Writing 0x0C = 1 clears `o_mtip` one cycle after the write lands.
- **mtime write and read-first:**
  - Stimulus: write 0x04 with data 0xAABBCCDD, byte-enable 4'b0101.
  - Response: `mtime[63:32]` = 0x00BB00DD and no increment in that cycle. A read of 0x04 in the same cycle returns the old value; a read the next cycle returns 0x00BB00DD.
- **Wrap and unmapped offsets:**
  - Set `mtime` = 2^64-1 → the next tick gives 0.
  - Read 0x18 → 0 with `o_rd_hit` = 1.
  - Read `BASE_ADDR` + 0x20 → `o_rd_hit` = 0, `o_rd_data` = 0.
- **msip and mid-count reset:**
  - Write 0x10 = 0xFFFFFFFF → `o_msip` = 1 and a readback of 0x10 returns 0x1.
  - Assert `i_rst` mid-count → all outputs are 0 immediately and `mtimecmp` reads back all ones.
